// File: rtl/window_3x3.sv
// 3x3 neighbourhood builder fed by three line-aligned pixel streams; emits only
// windows fully inside the frame. Define WINDOW_3X3_COORD_EN to add col_o/row_o.
module window_3x3 #(
   parameter int unsigned Width       = 8,
   parameter int unsigned LineWidth   = 640,
   parameter int unsigned FrameHeight = 480
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [Width-1:0]               row0_i,
   input  logic [Width-1:0]               row1_i,
   input  logic [Width-1:0]               row2_i,
   input  logic                           valid_i,
   output logic                           ready_o,
   output logic                           valid_o,
   output logic [9*Width-1:0]             window_o,
   input  logic                           ready_i
`ifdef WINDOW_3X3_COORD_EN
   ,
   output logic [$clog2(LineWidth)-1:0]   col_o,
   output logic [$clog2(FrameHeight)-1:0] row_o
`endif
);

   localparam int unsigned CW = $clog2(LineWidth);
   localparam int unsigned RW = $clog2(FrameHeight);
   localparam logic [CW-1:0] COL_LAST = CW'(LineWidth - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(FrameHeight - 1);

   logic [CW-1:0]              r_col_cnt;
   logic [RW-1:0]              r_row_cnt;
   // Two newest columns; the oldest column of a window lives only in window_o.
   logic [1:0][3*Width-1:0]    r_shift;
   logic                       r_valid;
   logic [9*Width-1:0]         r_window;

   logic                       w_in_fire;
   logic                       w_out_fire;
   logic                       w_emit;
   logic                       w_col_last;
   logic                       w_row_last;
   logic [3*Width-1:0]         w_new_col;
   logic [9*Width-1:0]         w_window;

   assign ready_o    = ~r_valid | ready_i;
   assign valid_o    = r_valid;
   assign window_o   = r_window;

   assign w_in_fire  = valid_i & ready_o;
   assign w_out_fire = r_valid & ready_i;
   assign w_col_last = (r_col_cnt == COL_LAST);
   assign w_row_last = (r_row_cnt == ROW_LAST);
   assign w_emit     = w_in_fire & (r_col_cnt >= CW'(2)) & (r_row_cnt >= RW'(2));

   // Column packing: row r=0 (oldest line) in the low bits.
   assign w_new_col  = {row0_i, row1_i, row2_i};

   always_comb begin
      w_window = '0;
      for (int unsigned r = 0; r < 3; r++) begin
         w_window[(r*3+0)*Width +: Width] = r_shift[0][r*Width +: Width];
         w_window[(r*3+1)*Width +: Width] = r_shift[1][r*Width +: Width];
         w_window[(r*3+2)*Width +: Width] = w_new_col[r*Width +: Width];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_col_cnt <= '0;
         r_row_cnt <= '0;
         r_shift   <= '0;
      end else if (w_in_fire) begin
         r_shift[0] <= r_shift[1];
         r_shift[1] <= w_new_col;
         if (w_col_last) begin
            r_col_cnt <= '0;
            r_row_cnt <= w_row_last ? '0 : r_row_cnt + RW'(1);
         end else begin
            r_col_cnt <= r_col_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid  <= 1'b0;
         r_window <= '0;
      end else if (w_emit) begin
         r_valid  <= 1'b1;
         r_window <= w_window;
      end else if (w_out_fire) begin
         r_valid  <= 1'b0;
      end
   end

`ifdef WINDOW_3X3_COORD_EN
   logic [CW-1:0] r_col_o;
   logic [RW-1:0] r_row_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_col_o <= '0;
         r_row_o <= '0;
      end else if (w_emit) begin
         r_col_o <= r_col_cnt;
         r_row_o <= r_row_cnt;
      end
   end

   assign col_o = r_col_o;
   assign row_o = r_row_o;
`endif

endmodule

// File: tb/tb_window_3x3.sv
// Bench for window_3x3 on a 4x4 frame against a frame-position reference model.
// Define WINDOW_3X3_COORD_EN to also exercise col_o/row_o.
module tb_window_3x3;
   localparam int unsigned W  = 8;
   localparam int unsigned LW = 4;
   localparam int unsigned FH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [W-1:0]     t_row0, t_row1, t_row2;
   logic             t_vin, t_rdy_in, t_rdy_out, t_vout;
   logic [9*W-1:0]   t_win;
`ifdef WINDOW_3X3_COORD_EN
   logic [1:0]       t_col, t_row;
`endif

   always #5 clk = ~clk;

   window_3x3 #(.Width(W), .LineWidth(LW), .FrameHeight(FH)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .row0_i   (t_row0),
      .row1_i   (t_row1),
      .row2_i   (t_row2),
      .valid_i  (t_vin),
      .ready_o  (t_rdy_out),
      .valid_o  (t_vout),
      .window_o (t_win),
      .ready_i  (t_rdy_in)
`ifdef WINDOW_3X3_COORD_EN
      ,
      .col_o    (t_col),
      .row_o    (t_row)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: position in frame plus every column triple seen on the current line.
   int           m_col, m_row, m_wcol, m_wrow;
   bit           m_valid;
   logic [W-1:0] m_win [9];
   logic [W-1:0] m_line [LW][3];
   bit           m_ready_pre;

   // Values sampled just before the active edge.
   bit           s_ready, s_vout;
   logic [9*W-1:0] s_win;
`ifdef WINDOW_3X3_COORD_EN
   int           s_col, s_row;
`endif

   function automatic void model_reset();
      m_col = 0; m_row = 0; m_wcol = 0; m_wrow = 0; m_valid = 0;
      for (int k = 0; k < 9; k++) m_win[k] = '0;
   endfunction

   function automatic void model_step(input bit v, input logic [W-1:0] p0, p1, p2,
                                      input bit rdy, output bit fired, output bit emitted);
      bit ready;
      ready   = !m_valid || rdy;
      fired   = v && ready;
      emitted = 0;
      if (fired) begin
         m_line[m_col][0] = p2;
         m_line[m_col][1] = p1;
         m_line[m_col][2] = p0;
         if (m_col >= 2 && m_row >= 2) begin
            emitted = 1;
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  m_win[r*3+c] = m_line[m_col-2+c][r];
            m_wcol = m_col;
            m_wrow = m_row;
         end
         if (m_col == LW-1) begin
            m_col = 0;
            m_row = (m_row == FH-1) ? 0 : m_row + 1;
         end else begin
            m_col = m_col + 1;
         end
      end
      if (emitted) m_valid = 1;
      else if (m_valid && rdy) m_valid = 0;
   endfunction

   function automatic logic [9*W-1:0] model_window();
      logic [9*W-1:0] w;
      for (int k = 0; k < 9; k++) w[k*W +: W] = m_win[k];
      return w;
   endfunction

   // Window whose newest pixel is linear index n in the index/index-4/index-8 stream.
   function automatic logic [9*W-1:0] formula_win(input int n);
      logic [9*W-1:0] w;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[(r*3+c)*W +: W] = W'(n - 2 - 2*LW + r*LW + c);
      return w;
   endfunction

   function automatic logic [W-1:0] clampv(input int v);
      return (v < 0) ? '0 : W'(v);
   endfunction

   task automatic cyc(input bit v, input logic [W-1:0] p0, p1, p2, input bit rdy,
                      output bit fired, output bit emitted);
      t_vin = v; t_row0 = p0; t_row1 = p1; t_row2 = p2; t_rdy_in = rdy;
      #1;
      s_ready = t_rdy_out; s_vout = t_vout; s_win = t_win;
`ifdef WINDOW_3X3_COORD_EN
      s_col = int'(t_col); s_row = int'(t_row);
`endif
      m_ready_pre = !m_valid || rdy;
      @(posedge clk);
      model_step(v, p0, p1, p2, rdy, fired, emitted);
      #1;
   endtask

   task automatic apply_reset();
      t_vin = 0; t_rdy_in = 1;
      rst_n = 0; #2; rst_n = 1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 0; t_vin = 0; t_rdy_in = 0;
      t_row0 = '0; t_row1 = '0; t_row2 = '0;
      @(posedge clk); #1;
      n_checks++; if (t_vout !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b want 0", t_vout); end
      n_checks++; if (t_win !== '0) begin n_errors++; $display("FAIL reset_window: got %h want 0", t_win); end
      n_checks++; if (t_rdy_out !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %0b want 1", t_rdy_out); end
      rst_n = 1;
      model_reset();
   endtask

   task automatic test_basic();
      int idx; bit f, e;
      logic [9*W-1:0] got[$];
      int exp_n[4];
`ifdef WINDOW_3X3_COORD_EN
      int gc[$], gr[$]; int ec[4], er[4];
      ec = '{2, 3, 2, 3}; er = '{2, 2, 3, 3};
`endif
      exp_n = '{10, 11, 14, 15};
      apply_reset();
      idx = 0;
      for (int cy = 0; cy < 24; cy++) begin
         cyc(idx < 16, clampv(idx), clampv(idx-4), clampv(idx-8), 1'b1, f, e);
         if (f) idx++;
         if (s_vout) begin
            got.push_back(s_win);
`ifdef WINDOW_3X3_COORD_EN
            gc.push_back(s_col); gr.push_back(s_row);
`endif
         end
         n_checks++; if (s_ready !== m_ready_pre) begin n_errors++; $display("FAIL basic_ready cy%0d: got %0b want %0b", cy, s_ready, m_ready_pre); end
         n_checks++; if (t_vout !== m_valid) begin n_errors++; $display("FAIL basic_valid cy%0d: got %0b want %0b", cy, t_vout, m_valid); end
         n_checks++; if (t_win !== model_window()) begin n_errors++; $display("FAIL basic_window cy%0d: got %h want %h", cy, t_win, model_window()); end
`ifdef WINDOW_3X3_COORD_EN
         n_checks++; if (int'(t_col) !== m_wcol || int'(t_row) !== m_wrow) begin n_errors++; $display("FAIL basic_coord cy%0d: got (%0d,%0d) want (%0d,%0d)", cy, t_col, t_row, m_wcol, m_wrow); end
`endif
      end
      n_checks++; if (idx != 16) begin n_errors++; $display("FAIL basic_timeout: consumed %0d want 16", idx); end
      n_checks++; if (got.size() != 4) begin n_errors++; $display("FAIL basic_count: got %0d want 4", got.size()); end
      for (int k = 0; k < got.size() && k < 4; k++) begin
         n_checks++; if (got[k] !== formula_win(exp_n[k])) begin n_errors++; $display("FAIL basic_win%0d: got %h want %h", k, got[k], formula_win(exp_n[k])); end
`ifdef WINDOW_3X3_COORD_EN
         n_checks++; if (gc[k] != ec[k] || gr[k] != er[k]) begin n_errors++; $display("FAIL basic_coordlist%0d: got (%0d,%0d) want (%0d,%0d)", k, gc[k], gr[k], ec[k], er[k]); end
`endif
      end
   endtask

   task automatic test_back_pressure();
      int idx, stall_left, idx_hold; bit f, e, rdy, stalled;
      logic [9*W-1:0] got[$]; logic [9*W-1:0] held;
      int exp_n[4];
      exp_n = '{10, 11, 14, 15};
      apply_reset();
      idx = 0; stall_left = 0; stalled = 0; held = '0; idx_hold = 0;
      for (int cy = 0; cy < 40; cy++) begin
         rdy = (stall_left == 0);
         cyc(idx < 16, clampv(idx), clampv(idx-4), clampv(idx-8), rdy, f, e);
         if (f) idx++;
         if (s_vout && rdy) got.push_back(s_win);
         n_checks++; if (s_ready !== m_ready_pre) begin n_errors++; $display("FAIL bp_ready cy%0d: got %0b want %0b", cy, s_ready, m_ready_pre); end
         n_checks++; if (t_vout !== m_valid) begin n_errors++; $display("FAIL bp_valid cy%0d: got %0b want %0b", cy, t_vout, m_valid); end
         n_checks++; if (t_win !== model_window()) begin n_errors++; $display("FAIL bp_window cy%0d: got %h want %h", cy, t_win, model_window()); end
         if (stall_left > 0) begin
            n_checks++; if (t_win !== held) begin n_errors++; $display("FAIL bp_stable cy%0d: got %h want %h", cy, t_win, held); end
            n_checks++; if (s_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready_low cy%0d: got %0b want 0", cy, s_ready); end
            n_checks++; if (idx != idx_hold) begin n_errors++; $display("FAIL bp_consumed cy%0d: got %0d want %0d", cy, idx, idx_hold); end
            stall_left--;
         end else if (!stalled && t_vout) begin
            held = t_win; stall_left = 5; stalled = 1; idx_hold = idx;
         end
      end
      n_checks++; if (idx != 16) begin n_errors++; $display("FAIL bp_timeout: consumed %0d want 16", idx); end
      n_checks++; if (got.size() != 4) begin n_errors++; $display("FAIL bp_count: got %0d want 4", got.size()); end
      for (int k = 0; k < got.size() && k < 4; k++) begin
         n_checks++; if (got[k] !== formula_win(exp_n[k])) begin n_errors++; $display("FAIL bp_win%0d: got %h want %h", k, got[k], formula_win(exp_n[k])); end
      end
   endtask

   task automatic test_two_frames();
      int idx; bit f, e;
      logic [9*W-1:0] got[$];
      int exp_n[8];
      exp_n = '{10, 11, 14, 15, 26, 27, 30, 31};
      apply_reset();
      idx = 0;
      for (int cy = 0; cy < 40; cy++) begin
         cyc(idx < 32, clampv(idx), clampv(idx-4), clampv(idx-8), 1'b1, f, e);
         if (f) idx++;
         if (s_vout) got.push_back(s_win);
         n_checks++; if (t_vout !== m_valid) begin n_errors++; $display("FAIL frames_valid cy%0d: got %0b want %0b", cy, t_vout, m_valid); end
         n_checks++; if (t_win !== model_window()) begin n_errors++; $display("FAIL frames_window cy%0d: got %h want %h", cy, t_win, model_window()); end
      end
      n_checks++; if (idx != 32) begin n_errors++; $display("FAIL frames_timeout: consumed %0d want 32", idx); end
      n_checks++; if (got.size() != 8) begin n_errors++; $display("FAIL frames_count: got %0d want 8", got.size()); end
      for (int k = 0; k < got.size() && k < 8; k++) begin
         n_checks++; if (got[k] !== formula_win(exp_n[k])) begin n_errors++; $display("FAIL frames_win%0d: got %h want %h", k, got[k], formula_win(exp_n[k])); end
      end
   endtask

   task automatic test_valid_toggle();
      int idx; bit f, e;
      logic [9*W-1:0] got[$];
      int exp_n[4];
      exp_n = '{10, 11, 14, 15};
      apply_reset();
      idx = 0;
      for (int cy = 0; cy < 40; cy++) begin
         cyc((cy % 2 == 0) && idx < 16, clampv(idx), clampv(idx-4), clampv(idx-8), 1'b1, f, e);
         if (f) idx++;
         if (s_vout) got.push_back(s_win);
         n_checks++; if (t_vout !== m_valid) begin n_errors++; $display("FAIL toggle_valid cy%0d: got %0b want %0b", cy, t_vout, m_valid); end
         n_checks++; if (t_win !== model_window()) begin n_errors++; $display("FAIL toggle_window cy%0d: got %h want %h", cy, t_win, model_window()); end
      end
      n_checks++; if (idx != 16) begin n_errors++; $display("FAIL toggle_timeout: consumed %0d want 16", idx); end
      n_checks++; if (got.size() != 4) begin n_errors++; $display("FAIL toggle_count: got %0d want 4", got.size()); end
      for (int k = 0; k < got.size() && k < 4; k++) begin
         n_checks++; if (got[k] !== formula_win(exp_n[k])) begin n_errors++; $display("FAIL toggle_win%0d: got %h want %h", k, got[k], formula_win(exp_n[k])); end
      end
   endtask

   task automatic test_reset_midframe();
      int idx; bit f, e;
      logic [9*W-1:0] got[$];
      int exp_n[4];
      exp_n = '{10, 11, 14, 15};
      apply_reset();
      idx = 0;
      for (int cy = 0; cy < 11; cy++) begin
         cyc(1'b1, clampv(idx), clampv(idx-4), clampv(idx-8), 1'b1, f, e);
         if (f) idx++;
      end
      n_checks++; if (t_vout !== 1'b1) begin n_errors++; $display("FAIL midreset_pre_valid: got %0b want 1", t_vout); end
      rst_n = 0;
      #1;
      n_checks++; if (t_vout !== 1'b0) begin n_errors++; $display("FAIL midreset_async_valid: got %0b want 0", t_vout); end
      n_checks++; if (t_win !== '0) begin n_errors++; $display("FAIL midreset_async_window: got %h want 0", t_win); end
      rst_n = 1;
      model_reset();
      idx = 0;
      for (int cy = 0; cy < 24; cy++) begin
         cyc(idx < 16, clampv(idx), clampv(idx-4), clampv(idx-8), 1'b1, f, e);
         if (f) idx++;
         if (s_vout) got.push_back(s_win);
         n_checks++; if (t_vout !== m_valid) begin n_errors++; $display("FAIL midreset_valid cy%0d: got %0b want %0b", cy, t_vout, m_valid); end
         n_checks++; if (t_win !== model_window()) begin n_errors++; $display("FAIL midreset_window cy%0d: got %h want %h", cy, t_win, model_window()); end
      end
      n_checks++; if (got.size() != 4) begin n_errors++; $display("FAIL midreset_count: got %0d want 4", got.size()); end
      for (int k = 0; k < got.size() && k < 4; k++) begin
         n_checks++; if (got[k] !== formula_win(exp_n[k])) begin n_errors++; $display("FAIL midreset_win%0d: got %h want %h", k, got[k], formula_win(exp_n[k])); end
      end
   endtask

   task automatic test_random();
      bit f, e, v, rdy;
      apply_reset();
      for (int cy = 0; cy < 300; cy++) begin
         v   = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         cyc(v, W'($urandom), W'($urandom), W'($urandom), rdy, f, e);
         n_checks++; if (s_ready !== m_ready_pre) begin n_errors++; $display("FAIL rand_ready cy%0d: got %0b want %0b", cy, s_ready, m_ready_pre); end
         n_checks++; if (t_vout !== m_valid) begin n_errors++; $display("FAIL rand_valid cy%0d: got %0b want %0b", cy, t_vout, m_valid); end
         n_checks++; if (t_win !== model_window()) begin n_errors++; $display("FAIL rand_window cy%0d: got %h want %h", cy, t_win, model_window()); end
`ifdef WINDOW_3X3_COORD_EN
         n_checks++; if (int'(t_col) !== m_wcol || int'(t_row) !== m_wrow) begin n_errors++; $display("FAIL rand_coord cy%0d: got (%0d,%0d) want (%0d,%0d)", cy, t_col, t_row, m_wcol, m_wrow); end
`endif
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_back_pressure();
      test_two_frames();
      test_valid_toggle();
      test_reset_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
